mipi_dphy_tx_lane_ctrl: RTL

- Byte-clock D-PHY transmit lane controller, successor to the single-lane serializer front end.
- Sequences LP-11 → LP-01 → LP-00 → HS-zero → SoT → payload → trail → LP-11 on 1..MAX_LANES data lanes.
- All protocol timings are runtime-programmable; the active lane count is selectable per burst.
- Emits per-lane parallel HS bytes and LP levels to external SerDes/IO; consumes one multi-lane beat per cycle over a valid/ready handshake.

---
 rtl/mipi_dphy_tx_lane_ctrl_pkg.sv | 14 +
 rtl/mipi_dphy_tx_lane_ctrl_if.sv | 7 +
 rtl/mipi_dphy_tx_lane_ctrl_timer.sv | 16 +
 rtl/mipi_dphy_tx_lane_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mipi_dphy_tx_lane_ctrl_pkg.sv
// mipi_tx_pkg: FSM states, LP line encodings and HS fill bytes (MIPI_TX_CLK_LANE_EN adds clock-lane states)
package mipi_tx_pkg;
    typedef enum logic [3:0] {
        ST_STOP, ST_LPX, ST_PREPARE, ST_ZERO, ST_SYNC, ST_HST, ST_TRAIL, ST_EXIT
`ifdef MIPI_TX_CLK_LANE_EN
        , ST_CLK_LPX, ST_CLK_PREP, ST_CLK_PRE, ST_CLK_POST
`endif
    } state_t;
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [7:0] ZERO_BYTE = 8'h00;
endpackage

// File: rtl/mipi_dphy_tx_lane_ctrl_if.sv
// mipi_dphy_tx_lane_ctrl_if: multi-lane beat stream feeding the D-PHY TX lane controller
interface mipi_dphy_tx_lane_ctrl_if #(parameter int MAX_LANES = 4);
    logic s_valid, s_ready, s_last;
    logic [8*MAX_LANES-1:0] s_data;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/mipi_dphy_tx_lane_ctrl_timer.sv
// mipi_tx_timer: loadable down-counter; a load of v gives max(v,1) cycles until done
module mipi_tx_timer #(parameter int CNT_W = 8) (
    input  logic             clk_hs,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk_hs) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= (value == '0) ? '0 : value - CNT_W'(1);
        else if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
    assign done = cnt == '0;
endmodule

// File: rtl/mipi_dphy_tx_lane_ctrl.sv
// mipi_dphy_tx_lane_ctrl: D-PHY TX data-lane sequencer; MIPI_TX_CLK_LANE_EN adds clock-lane control
module mipi_dphy_tx_lane_ctrl
    import mipi_tx_pkg::*;
#(
    parameter int MAX_LANES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                   clk_hs,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [3:0]             num_active_lanes,
    input  logic [CNT_W-1:0]       t_lpx,
    input  logic [CNT_W-1:0]       t_prepare,
    input  logic [CNT_W-1:0]       t_zero,
    input  logic [CNT_W-1:0]       t_trail,
    input  logic [CNT_W-1:0]       t_exit,
`ifdef MIPI_TX_CLK_LANE_EN
    input  logic [CNT_W-1:0]       t_clk_pre,
    input  logic [CNT_W-1:0]       t_clk_post,
    output logic                   clk_hs_en,
    output logic                   clk_lp_p,
    output logic                   clk_lp_n,
`endif
    mipi_dphy_tx_lane_ctrl_if.slave s,
    output logic [8*MAX_LANES-1:0] hs_data,
    output logic [MAX_LANES-1:0]   hs_en,
    output logic [MAX_LANES-1:0]   lp_p,
    output logic [MAX_LANES-1:0]   lp_n,
    output logic                   busy,
    output logic                   underrun
);
`ifdef MIPI_TX_CLK_LANE_EN
    localparam state_t START = ST_CLK_LPX;
    localparam state_t POST  = ST_CLK_POST;
`else
    localparam state_t START = ST_LPX;
    localparam state_t POST  = ST_EXIT;
`endif
    state_t state, nxt;
    logic done, load, fire, rdy, hs;
    logic [CNT_W-1:0] tval;
    logic [MAX_LANES-1:0] act, eff, m;
    logic [1:0] lp;
    logic [3:0] n;
    assign n = (num_active_lanes == 4'd0) ? 4'd1 :
               (int'(num_active_lanes) > MAX_LANES) ? 4'(MAX_LANES) : num_active_lanes;
    always_comb begin
        eff = '0;
        for (int i = 0; i < MAX_LANES; i++) eff[i] = i < int'(n);
    end
    // lane mask is taken live on the STOP exit edge, then frozen for the burst
    assign m = (state == ST_STOP) ? eff : act;
    assign s.s_ready = rdy;
    assign fire = s.s_valid && rdy;
    always_comb begin
        nxt = state;
        case (state)
            ST_STOP:     if (enable && s.s_valid) nxt = START;
`ifdef MIPI_TX_CLK_LANE_EN
            ST_CLK_LPX:  if (done) nxt = ST_CLK_PREP;
            ST_CLK_PREP: if (done) nxt = ST_CLK_PRE;
            ST_CLK_PRE:  if (done) nxt = ST_LPX;
            ST_CLK_POST: if (done) nxt = ST_EXIT;
`endif
            ST_LPX:      if (done) nxt = ST_PREPARE;
            ST_PREPARE:  if (done) nxt = ST_ZERO;
            ST_ZERO:     if (done) nxt = ST_SYNC;
            ST_SYNC:     nxt = s.s_valid ? ST_HST : ST_TRAIL;
            ST_HST:      if (!rdy || !s.s_valid) nxt = ST_TRAIL;
            ST_TRAIL:    if (done) nxt = POST;
            ST_EXIT:     if (done) nxt = ST_STOP;
            default:     nxt = ST_STOP;
        endcase
    end
    assign load = nxt != state;
    assign tval = (nxt == ST_LPX) ? t_lpx : (nxt == ST_PREPARE) ? t_prepare :
                  (nxt == ST_ZERO) ? t_zero : (nxt == ST_TRAIL) ? t_trail :
`ifdef MIPI_TX_CLK_LANE_EN
                  (nxt == ST_CLK_LPX) ? t_lpx : (nxt == ST_CLK_PREP) ? t_prepare :
                  (nxt == ST_CLK_PRE) ? t_clk_pre : (nxt == ST_CLK_POST) ? t_clk_post :
`endif
                  t_exit;
    assign lp = (nxt == ST_LPX) ? LP01 :
                (nxt inside {ST_PREPARE, ST_ZERO, ST_SYNC, ST_HST, ST_TRAIL}) ? LP00 : LP11;
    assign hs = nxt inside {ST_ZERO, ST_SYNC, ST_HST, ST_TRAIL};
    mipi_tx_timer #(.CNT_W(CNT_W)) timer (
        .clk_hs(clk_hs), .reset(reset), .load(load), .value(tval), .done(done)
    );
    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk_hs) begin
        if (reset) begin
            state    <= ST_STOP;
            act      <= '0;
            hs_data  <= '0;
            hs_en    <= '0;
            lp_p     <= '1;
            lp_n     <= '1;
            rdy      <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= nxt;
            act   <= m;
            busy  <= nxt != ST_STOP;
            rdy   <= (nxt == ST_SYNC) || (nxt == ST_HST && !(fire && s.s_last));
            if (rdy && !s.s_valid) underrun <= 1'b1;
            for (int i = 0; i < MAX_LANES; i++) begin
                hs_en[i] <= m[i] && hs;
                lp_p[i]  <= !m[i] || lp[1];
                lp_n[i]  <= !m[i] || lp[0];
                hs_data[8*i+:8] <= !m[i] ? 8'h00 :
                                   (nxt == ST_ZERO) ? ZERO_BYTE :
                                   (nxt == ST_SYNC) ? SYNC_BYTE :
                                   (nxt == ST_HST) ? s.s_data[8*i+:8] :
                                   (nxt == ST_TRAIL) ? ((state == ST_TRAIL) ? hs_data[8*i+:8] : {8{~hs_data[8*i+7]}}) :
                                   8'h00;
            end
        end
    end
`ifdef MIPI_TX_CLK_LANE_EN
    always_ff @(posedge clk_hs) begin
        if (reset) begin
            clk_hs_en <= 1'b0;
            clk_lp_p  <= 1'b1;
            clk_lp_n  <= 1'b1;
        end else begin
            clk_hs_en <= !(nxt inside {ST_STOP, ST_EXIT, ST_CLK_LPX, ST_CLK_PREP});
            clk_lp_p  <= nxt inside {ST_STOP, ST_EXIT};
            clk_lp_n  <= nxt inside {ST_STOP, ST_EXIT, ST_CLK_LPX};
        end
    end
`endif
endmodule
